// File: rtl/cic_interpolator.sv
// rtl/cic_interpolator.sv - N-stage I/Q CIC interpolator with valid/ready, runtime rate, gain shift and saturation
module cic_interpolator #(
  parameter int DATA_WIDTH    = 18,
  parameter int OUTPUT_WIDTH  = 18,
  parameter int CIC_STAGES    = 3,
  parameter int MAX_RATE_LOG2 = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    flush,
  input  logic [7:0]              interp_rate,
  input  logic [5:0]              out_shift,
  input  logic [DATA_WIDTH-1:0]   i_data_in,
  input  logic [DATA_WIDTH-1:0]   q_data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic [OUTPUT_WIDTH-1:0] i_data_out,
  output logic [OUTPUT_WIDTH-1:0] q_data_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             status
);

  localparam int ACC_WIDTH = DATA_WIDTH + CIC_STAGES * MAX_RATE_LOG2;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  localparam acc_t SAT_MAX = {{(ACC_WIDTH-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam acc_t SAT_MIN = {{(ACC_WIDTH-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  // Channel index 0 is I, 1 is Q throughout.
  acc_t                    dly_q   [2][CIC_STAGES];
  acc_t                    dly_d   [2][CIC_STAGES];
  acc_t                    integ_q [2][CIC_STAGES];
  acc_t                    integ_d [2][CIC_STAGES];
  acc_t                    pend_q  [2];
  acc_t                    pend_d  [2];
  logic [OUTPUT_WIDTH-1:0] out_q   [2];
  logic [OUTPUT_WIDTH-1:0] out_d   [2];

  logic       pend_full_q, pend_full_d;
  logic       out_valid_q, out_valid_d;
  logic       underrun_q, underrun_d;
  logic       sat_q, sat_d;
  logic       started_q, started_d;
  logic [7:0] phase_q, phase_d;
  logic [7:0] rate_q, rate_d;
  logic [5:0] shift_q, shift_d;

  acc_t       comb_v    [2][CIC_STAGES+1];
  acc_t       integ_v   [2][CIC_STAGES];
  acc_t       x_v       [2];
  acc_t       shifted_v [2];
  logic       out_free, step, consume, accept;
  logic [7:0] rate_eff;
  logic [5:0] shift_eff;

  always_comb begin
    out_free   = !out_valid_q || out_ready;
    step       = enable && out_free && ((phase_q != 8'd0) || pend_full_q);
    consume    = step && (phase_q == 8'd0);
    data_ready = enable && (!pend_full_q || consume);
    accept     = data_valid && data_ready;

    // New configuration is only picked up at an input-sample boundary.
    rate_eff  = rate_q;
    shift_eff = shift_q;
    if (phase_q == 8'd0) begin
      rate_eff  = (interp_rate == 8'd0) ? 8'd1 : interp_rate;
      shift_eff = out_shift;
    end

    comb_v[0][0] = {{(ACC_WIDTH-DATA_WIDTH){i_data_in[DATA_WIDTH-1]}}, i_data_in};
    comb_v[1][0] = {{(ACC_WIDTH-DATA_WIDTH){q_data_in[DATA_WIDTH-1]}}, q_data_in};
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < CIC_STAGES; k++) begin
        comb_v[c][k+1] = comb_v[c][k] - dly_q[c][k];
      end
      x_v[c]        = consume ? pend_q[c] : '0;
      integ_v[c][0] = integ_q[c][0] + x_v[c];
      for (int k = 1; k < CIC_STAGES; k++) begin
        integ_v[c][k] = integ_q[c][k] + integ_v[c][k-1];
      end
      shifted_v[c] = integ_v[c][CIC_STAGES-1] >>> shift_eff;
    end

    dly_d       = dly_q;
    integ_d     = integ_q;
    pend_d      = pend_q;
    out_d       = out_q;
    pend_full_d = pend_full_q;
    out_valid_d = out_valid_q;
    underrun_d  = underrun_q;
    sat_d       = sat_q;
    started_d   = started_q;
    phase_d     = phase_q;
    rate_d      = rate_q;
    shift_d     = shift_q;

    if (step) begin
      integ_d = integ_v;
      for (int c = 0; c < 2; c++) begin
        if (shifted_v[c] > SAT_MAX) begin
          out_d[c] = SAT_MAX[OUTPUT_WIDTH-1:0];
          sat_d    = 1'b1;
        end else if (shifted_v[c] < SAT_MIN) begin
          out_d[c] = SAT_MIN[OUTPUT_WIDTH-1:0];
          sat_d    = 1'b1;
        end else begin
          out_d[c] = shifted_v[c][OUTPUT_WIDTH-1:0];
        end
      end
      out_valid_d = 1'b1;
      phase_d     = (phase_q == rate_eff - 8'd1) ? 8'd0 : phase_q + 8'd1;
      rate_d      = rate_eff;
      shift_d     = shift_eff;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (consume) begin
      pend_full_d = 1'b0;
    end

    // A refill in the same cycle as consume keeps R=1 at full rate.
    if (accept) begin
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < CIC_STAGES; k++) begin
          dly_d[c][k] = comb_v[c][k];
        end
        pend_d[c] = comb_v[c][CIC_STAGES];
      end
      pend_full_d = 1'b1;
      started_d   = 1'b1;
    end

    if (enable && (phase_q == 8'd0) && !pend_full_q && out_free && started_q) begin
      underrun_d = 1'b1;
    end

    if (flush) begin
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < CIC_STAGES; k++) begin
          dly_d[c][k]   = '0;
          integ_d[c][k] = '0;
        end
        pend_d[c] = '0;
        out_d[c]  = '0;
      end
      pend_full_d = 1'b0;
      out_valid_d = 1'b0;
      underrun_d  = 1'b0;
      sat_d       = 1'b0;
      started_d   = 1'b0;
      phase_d     = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < CIC_STAGES; k++) begin
          dly_q[c][k]   <= '0;
          integ_q[c][k] <= '0;
        end
        pend_q[c] <= '0;
        out_q[c]  <= '0;
      end
      pend_full_q <= 1'b0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      sat_q       <= 1'b0;
      started_q   <= 1'b0;
      phase_q     <= 8'd0;
      rate_q      <= 8'd1;
      shift_q     <= 6'd0;
    end else begin
      dly_q       <= dly_d;
      integ_q     <= integ_d;
      pend_q      <= pend_d;
      out_q       <= out_d;
      pend_full_q <= pend_full_d;
      out_valid_q <= out_valid_d;
      underrun_q  <= underrun_d;
      sat_q       <= sat_d;
      started_q   <= started_d;
      phase_q     <= phase_d;
      rate_q      <= rate_d;
      shift_q     <= shift_d;
    end
  end

  assign i_data_out = out_q[0];
  assign q_data_out = out_q[1];
  assign out_valid  = out_valid_q;
  assign status     = {phase_q, 4'b0000, sat_q, underrun_q, out_valid_q, pend_full_q};

endmodule

// File: tb/tb_cic_interpolator.sv
// tb/tb_cic_interpolator.sv - self-checking bench for cic_interpolator against a convolution reference
module tb_cic_interpolator;

  localparam int N = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b1;
  logic               flush = 1'b0;
  logic [7:0]         interp_rate = 8'd1;
  logic [5:0]         out_shift = 6'd0;
  logic signed [17:0] i_data_in = '0;
  logic signed [17:0] q_data_in = '0;
  logic               data_valid = 1'b0;
  logic               data_ready;
  logic [17:0]        i_data_out;
  logic [17:0]        q_data_out;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [15:0]        status;

  cic_interpolator dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .interp_rate(interp_rate), .out_shift(out_shift),
    .i_data_in(i_data_in), .q_data_in(q_data_in),
    .data_valid(data_valid), .data_ready(data_ready),
    .i_data_out(i_data_out), .q_data_out(q_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .status(status)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int stim_i[$], stim_q[$];
  int exp_i[$], exp_q[$];
  int got_i[$], got_q[$];
  int model_sat;

  typedef struct {
    int rate;
    int shift;
    int in_i;
    int in_q;
    int exp_i;
    int exp_q;
    int exp_sat;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Output capture plus protocol properties that must hold on every cycle.
  logic hold_prev = 1'b0;
  logic [17:0] hold_i, hold_q;
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_prev) begin
        n_cmp++;
        if (!(out_valid && i_data_out == hold_i && q_data_out == hold_q)) begin
          n_bad++;
          $display("FAIL hold_stable: got v=%0b i=%0d q=%0d, expected v=1 i=%0d q=%0d",
                   out_valid, i_data_out, q_data_out, hold_i, hold_q);
        end
      end
      if (!enable) check("ready_when_disabled", data_ready, 0);
      if (status[0] && out_valid && !out_ready) check("ready_when_stalled", data_ready, 0);
      if (out_valid && out_ready) begin
        got_i.push_back(int'($signed(i_data_out)));
        got_q.push_back(int'($signed(q_data_out)));
      end
    end
    hold_prev = out_valid && !out_ready && !flush && !rst;
    hold_i    = i_data_out;
    hold_q    = q_data_out;
  end

  // Reference: zero-stuff by R, then filter with (boxcar of length R)^N, shift, clamp.
  task automatic build_model(input int rate, input int shift);
    longint h[$];
    longint t[$];
    longint acc, v;
    int r;
    r = (rate == 0) ? 1 : rate;
    h.delete();
    h.push_back(1);
    for (int s = 0; s < N; s++) begin
      t.delete();
      for (int n = 0; n < h.size() + r - 1; n++) begin
        acc = 0;
        for (int j = 0; j < r; j++)
          if (n - j >= 0 && n - j < h.size()) acc += h[n-j];
        t.push_back(acc);
      end
      h = t;
    end
    exp_i.delete();
    exp_q.delete();
    model_sat = 0;
    for (int n = 0; n < stim_i.size() * r; n++) begin
      for (int ch = 0; ch < 2; ch++) begin
        acc = 0;
        for (int j = 0; j < h.size(); j++) begin
          int m;
          m = n - j;
          if (m >= 0 && (m % r) == 0)
            acc += h[j] * longint'((ch == 0) ? stim_i[m/r] : stim_q[m/r]);
        end
        v = acc >>> shift;
        if (v > 131071) begin v = 131071; model_sat = 1; end
        if (v < -131072) begin v = -131072; model_sat = 1; end
        if (ch == 0) exp_i.push_back(int'(v));
        else         exp_q.push_back(int'(v));
      end
    end
  endtask

  task automatic compare_all(input string name);
    check({name, "_count"}, got_i.size(), exp_i.size());
    for (int k = 0; k < got_i.size() && k < exp_i.size(); k++) begin
      check($sformatf("%s_i[%0d]", name, k), got_i[k], exp_i[k]);
      check($sformatf("%s_q[%0d]", name, k), got_q[k], exp_q[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input int rate, input int shift);
    interp_rate = rate[7:0];
    out_shift   = shift[5:0];
    data_valid  = 1'b0;
    enable      = 1'b1;
    out_ready   = 1'b1;
    flush       = 1'b1;
    tick();
    flush = 1'b0;
    got_i.delete();
    got_q.delete();
  endtask

  // Feeds stim_* and waits for all R outputs per input; out_ready forced low in a window.
  task automatic run_stream(input int rate, input int pvalid, input int pready, input int pen,
                            input int stall_at, input int stall_len);
    int idx, cyc, need, n;
    idx  = 0;
    cyc  = 0;
    n    = stim_i.size();
    need = n * ((rate == 0) ? 1 : rate);
    while ((idx < n || got_i.size() < need) && cyc < 3000) begin
      data_valid = (idx < n) && ($urandom_range(0, 99) < pvalid);
      if (idx < n) begin
        i_data_in = stim_i[idx][17:0];
        q_data_in = stim_q[idx][17:0];
      end
      enable    = ($urandom_range(0, 99) < pen);
      out_ready = ($urandom_range(0, 99) < pready);
      if (cyc >= stall_at && cyc < stall_at + stall_len) begin
        out_ready = 1'b0;
        enable    = 1'b1;
      end
      @(negedge clk);
      if (cyc == stall_at + stall_len - 1) begin
        check("stall_pend_full", status[0], 1);
        check("stall_ready_low", data_ready, 0);
        check("stall_out_valid", out_valid, 1);
      end
      if (data_valid && data_ready) idx++;
      tick();
      cyc++;
    end
    data_valid = 1'b0;
    enable     = 1'b1;
    out_ready  = 1'b1;
    if (cyc >= 3000) check("run_stream_timeout", got_i.size(), need);
  endtask

  initial begin
    int first_acc, first_out, last_out, drops, k, cnt, r, sh;
    int imp_exp[6];
    int und_exp[4];
    imp_exp = '{1, 3, 3, 1, 0, 0};
    und_exp = '{1, 3, 6, 10};

    vt[0] = '{4,  4,  1000,    -1000,   1000,    -1000,   0};
    vt[1] = '{2,  2,  500,     -300,    500,     -300,    0};
    vt[2] = '{4,  3,  131071,  -131072, 131071,  -131072, 1};
    vt[3] = '{1,  0,  12345,   -54321,  12345,   -54321,  0};
    vt[4] = '{8,  6,  7,       -8,      7,       -8,      0};
    vt[5] = '{0,  0,  100,     -100,    100,     -100,    0};
    vt[6] = '{3,  0,  10,      -10,     90,      -90,     0};
    vt[7] = '{16, 8,  -4096,   4095,    -4096,   4095,    0};

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_status", status, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_i_out", i_data_out, 0);
    check("reset_q_out", q_data_out, 0);
    check("reset_data_ready", data_ready, 1);
    tick();

    // Steady-state DC gain R^(N-1) >>> shift, with clamping.
    for (int v = 0; v < 8; v++) begin
      do_flush(vt[v].rate, vt[v].shift);
      stim_i.delete();
      stim_q.delete();
      repeat (8) begin
        stim_i.push_back(vt[v].in_i);
        stim_q.push_back(vt[v].in_q);
      end
      run_stream(vt[v].rate, 100, 100, 100, -10, 0);
      check($sformatf("vec%0d_steady_i", v), (got_i.size() > 0) ? got_i[got_i.size()-1] : -999999, vt[v].exp_i);
      check($sformatf("vec%0d_steady_q", v), (got_q.size() > 0) ? got_q[got_q.size()-1] : -999999, vt[v].exp_q);
      check($sformatf("vec%0d_sat_sticky", v), status[3], vt[v].exp_sat);
      build_model(vt[v].rate, vt[v].shift);
      compare_all($sformatf("vec%0d", v));
    end

    // Impulse at R=2: 1,3,3,1 then silence.
    do_flush(2, 0);
    stim_i = '{1, 0, 0, 0, 0};
    stim_q = '{0, 0, 0, 0, 0};
    run_stream(2, 100, 100, 100, -10, 0);
    for (int j = 0; j < 6; j++)
      check($sformatf("impulse_i[%0d]", j), (j < got_i.size()) ? got_i[j] : -999999, imp_exp[j]);
    build_model(2, 0);
    compare_all("impulse");

    // R=4 steady streaming: input taken once per four clocks.
    do_flush(4, 4);
    data_valid = 1'b1;
    i_data_in  = 18'sd1000;
    q_data_in  = -18'sd1000;
    repeat (20) tick();
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (data_ready) cnt++;
      tick();
    end
    check("r4_ready_duty", cnt, 10);
    data_valid = 1'b0;
    repeat (20) tick();

    // R=1 ramp: one output per clock, output visible two sample points after the accept.
    do_flush(1, 0);
    stim_i.delete();
    stim_q.delete();
    k = 0; first_acc = -1; first_out = -1; last_out = -1; drops = 0;
    for (int cyc = 0; cyc < 110; cyc++) begin
      data_valid = (k < 100);
      i_data_in  = k[17:0];
      q_data_in  = -k;
      @(negedge clk);
      if (data_valid && !data_ready) drops++;
      if (data_valid && data_ready) begin
        if (first_acc < 0) first_acc = cyc;
        stim_i.push_back(k);
        stim_q.push_back(-k);
        k++;
      end
      if (out_valid) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      tick();
    end
    data_valid = 1'b0;
    check("ramp_ready_drops", drops, 0);
    check("ramp_latency", first_out - first_acc, 2);
    check("ramp_span", last_out - first_out, 99);
    build_model(1, 0);
    compare_all("ramp");

    // Backpressure window mid-burst must not change the sequence.
    do_flush(4, 0);
    stim_i.delete();
    stim_q.delete();
    repeat (6) begin
      stim_i.push_back(int'($urandom_range(0, 2000)) - 1000);
      stim_q.push_back(int'($urandom_range(0, 2000)) - 1000);
    end
    run_stream(4, 100, 100, 100, 8, 5);
    build_model(4, 0);
    compare_all("backpressure");

    // Single sample then starve: gapped output, underrun sticky, flush gives clean state.
    do_flush(4, 0);
    stim_i = '{1};
    stim_q = '{0};
    run_stream(4, 100, 100, 100, -10, 0);
    repeat (6) tick();
    @(negedge clk);
    check("underrun_out_valid", out_valid, 0);
    check("underrun_sticky", status[2], 1);
    check("underrun_count", got_i.size(), 4);
    tick();
    do_flush(4, 0);
    @(negedge clk);
    check("flush_status", status, 0);
    tick();
    stim_i = '{1, 0, 0, 0};
    stim_q = '{0, 0, 0, 0};
    run_stream(4, 100, 100, 100, -10, 0);
    for (int j = 0; j < 4; j++)
      check($sformatf("post_flush_i[%0d]", j), (j < got_i.size()) ? got_i[j] : -999999, und_exp[j]);
    build_model(4, 0);
    compare_all("post_flush");

    // Random segments with random valid, ready and enable stalls.
    for (int s = 0; s < 6; s++) begin
      r  = $urandom_range(0, 12);
      sh = $urandom_range(0, 10);
      do_flush(r, sh);
      stim_i.delete();
      stim_q.delete();
      repeat (10) begin
        stim_i.push_back(int'($urandom_range(0, 262143)) - 131072);
        stim_q.push_back(int'($urandom_range(0, 262143)) - 131072);
      end
      run_stream(r, 70, 70, 85, -10, 0);
      build_model(r, sh);
      compare_all($sformatf("rand%0d", s));
      check($sformatf("rand%0d_sat_sticky", s), status[3], model_sat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/cic_interpolator.md
Name: cic_interpolator

Overview:
Transmit-path I/Q interpolation block, the upsampling counterpart of the receive decimation chain. It takes baseband I/Q at the low rate over a valid/ready interface. It runs an N-stage CIC interpolator (combs at input rate, zero-stuff by R, integrators at output rate) with configurable rate, gain-normalising shift and output saturation. It feeds the DUC/DAC side through a valid/ready output.

Parameters:
DATA_WIDTH, 18, input sample width (signed two's complement)
OUTPUT_WIDTH, 18, output sample width (signed)
CIC_STAGES, 3, number of comb and integrator stages N (1..6); differential delay fixed at 1
MAX_RATE_LOG2, 8, log2 of max rate; internal ACC_WIDTH = DATA_WIDTH + CIC_STAGES*MAX_RATE_LOG2

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
enable  in  1  0 = stall: data_ready=0, no step; output register still drains via out_ready
flush  in  1  synchronous clear of datapath state; configuration inputs unaffected
interp_rate  in  8  rate R; 0 treated as 1
out_shift  in  6  arithmetic right shift applied to last integrator before saturation
i_data_in  in  DATA_WIDTH  I sample, signed
q_data_in  in  DATA_WIDTH  Q sample, signed
data_valid  in  1  input valid
data_ready  out  1  input ready
i_data_out  out  OUTPUT_WIDTH  I output, signed
q_data_out  out  OUTPUT_WIDTH  Q output, signed
out_valid  out  1  output valid
out_ready  in  1  downstream ready
status  out  16  [0] pend_full, [1] out_valid, [2] underrun sticky, [3] saturation sticky, [7:4] 0, [15:8] phase counter

Behaviour:
- Reset (rst=1 at edge): all combs, integrators, pend, phase, sticky bits, started flag = 0. i/q_data_out = 0, out_valid = 0, status = 0. Reset wins over flush and enable. Mid-operation reset discards all in-flight data.
- flush=1 at edge: same clears as reset except configuration. Takes precedence over a simultaneous accept or step.
- Accept = data_valid && data_ready.
- On accept: comb cascade updates. c0 = sign-extended input; ck = c(k-1) - delay_k; delay_k <= c(k-1). Pend register <= cN for I and Q. pend_full <= 1. started <= 1.
- Step = enable && (!out_valid || out_ready) && (phase != 0 || pend_full).
- On step:
  - At phase==0, x = pend and pend is consumed. Otherwise x = 0 (zero-stuff).
  - All integrators update in one cycle with exact ripple: I1 += x; Ik += new I(k-1).
  - Output register loads sat(IN_new >>> out_shift). out_valid <= 1.
  - phase <= (phase == R_q-1) ? 0 : phase+1.
- R_q and shift_q latch interp_rate and out_shift on each phase-0 step. Config changes mid-sample take effect at the next input-sample boundary.
- data_ready = enable && (!pend_full || consume), where consume = step at phase 0. Same-cycle refill is allowed, so R=1 sustains one sample per clock.
- No step and out_ready=1: out_valid <= 0. Output data holds while out_valid && !out_ready.
- Latency: sample accepted at edge E0 → pend at E0 → output loaded at E1, if the output register is free. R outputs per input.
- Arithmetic: all internal values ACC_WIDTH, two's-complement wrap (valid CIC property). Saturation clamps to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1] and sets saturation sticky.
- DC gain = R^(N-1). Unity gain when out_shift = (N-1)*log2(R) for power-of-2 R.
- Underrun: phase==0, !pend_full, output register free, started=1, enable=1 → underrun sticky set. No step, so the output is gapped, not zero-filled. Integrator state is held.
- Underrun and saturation sticky bits clear only on rst or flush.
- enable=0 mid-burst: phase, integrators and pend frozen. Resumes exactly where it stopped.

Test Plan:
- N=3, R=2, shift=0, input I=1 then I=0 continuously, out_ready=1 → I outputs 1,3,3,1,0,0…; Q=0 throughout.
- N=3, R=4, shift=4, constant I=1000, Q=-1000 → after transient of at most 12 outputs, outputs steady at 1000/-1000. data_ready is high 1 cycle in 4.
- R=1, shift=0, ramp 0..99 at data_valid=1 every cycle → outputs equal the ramp, one per clock, first output 1 cycle after first accept.
- R=4, shift=3, constant I=131071, Q=-131072 → outputs clamp to 131071/-131072; status[3]=1.
- Backpressure: R=4, out_ready low for 5 cycles mid-burst → data held stable, data_ready=0 once pend full. Output sequence matches an unstalled reference run.
- Underrun then flush: one sample at R=4, then no input → 4 outputs, out_valid drops, status[2]=1. flush → status=0. New impulse gives a clean 1,3,3,1-type response with no residue.
